// File: rtl/fifo_rd_ctrl_x10.sv
// Read-side sequencer for the 10-lane RNS digit FIFO bank: lock-step reads,
// latency realignment into a small output buffer, and lane-skew detection.
module fifo_rd_ctrl_x10 #(
  parameter int WATERMARK = 1,
  parameter int SKEW_MAX  = 4,
  parameter int RD_LAT    = 1
) (
  input  logic         rd_clk,
  input  logic         sync_clr,
  input  logic         enable,
  input  logic         flush,
  input  logic         err_clr,
  input  logic [9:0]   rd_empty_,
  input  logic [8:0]   rd_used,
  input  logic [179:0] fifo_q,
  output logic         rd_req,
  output logic [179:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lane_err,
  output logic [9:0]   err_lanes,
  output logic [15:0]  word_cnt
);

  localparam int         W       = 180;
  localparam int         DEPTH   = RD_LAT + 1;
  localparam logic [8:0] WM      = 9'(WATERMARK);
  localparam logic [3:0] SKEW_TH = 4'(SKEW_MAX);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

  state_t               state_q, state_d;
  logic [DEPTH*W-1:0]   buf_q, buf_d;
  logic [2:0]           occ_q, occ_d;
  logic [RD_LAT-1:0]    infl_sr_q, infl_sr_d;
  logic [3:0]           skew_q, skew_d;
  logic                 lane_err_q, lane_err_d;
  logic [9:0]           err_lanes_q, err_lanes_d;
  logic                 clr_pend_q, clr_pend_d;
  logic [15:0]          word_cnt_q, word_cnt_d;

  logic       pop, capture, mismatch, skew_hit, credit_ok, level_ok;
  logic [2:0] infl, wr_idx;
  logic [3:0] skew_inc, outstanding;

  assign out_valid = (occ_q != 3'd0);
  assign out_data  = buf_q[W-1:0];
  assign lane_err  = lane_err_q;
  assign err_lanes = err_lanes_q;
  assign word_cnt  = word_cnt_q;

  assign pop      = out_valid & out_ready;
  assign capture  = infl_sr_q[RD_LAT-1];
  assign mismatch = (rd_empty_ != 10'h000) && (rd_empty_ != 10'h3FF);
  assign skew_inc = !mismatch ? 4'd0 : (skew_q == 4'hF) ? 4'hF : skew_q + 4'd1;
  assign skew_hit = mismatch && (skew_inc >= SKEW_TH);
  assign level_ok = flush || (rd_used >= WM);

  always_comb begin
    infl = 3'd0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + {2'b00, infl_sr_q[i]};
  end

  // Reads already in flight reserve a buffer slot, so the buffer cannot overflow.
  assign outstanding = {1'b0, occ_q} + {1'b0, infl} - {3'b000, pop};
  assign credit_ok   = (outstanding < DEPTH_C);

  always_ff @(posedge rd_clk) begin
    if (sync_clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_err_d  = lane_err_q;
    err_lanes_d = err_lanes_q;
    clr_pend_d  = clr_pend_q;
    skew_d      = skew_inc;
    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN: begin
        if (skew_hit)     state_d = ERR;
        else if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (skew_hit)          state_d = ERR;
        else if (infl == 3'd0) state_d = IDLE;
      end
      ERR: begin
        if ((err_clr || clr_pend_q) && infl == 3'd0) begin
          state_d     = IDLE;
          clr_pend_d  = 1'b0;
          lane_err_d  = 1'b0;
          err_lanes_d = 10'h000;
          skew_d      = 4'd0;
        end else if (err_clr) begin
          clr_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == RUN || state_q == DRAIN) && skew_hit) begin
      lane_err_d  = 1'b1;
      err_lanes_d = rd_empty_;
    end
  end

  always_comb begin
    rd_req = (state_q == RUN) && (rd_empty_ == 10'h000) && level_ok && credit_ok;
  end

  // Head of the buffer is always entry 0; a pop shifts everything down one slot.
  assign wr_idx = occ_q - {2'b00, pop};

  always_comb begin
    buf_d = pop ? (buf_q >> W) : buf_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (capture && wr_idx == 3'(i)) buf_d[i*W +: W] = fifo_q;
    end
    occ_d        = occ_q + {2'b00, capture} - {2'b00, pop};
    infl_sr_d    = infl_sr_q;
    infl_sr_d[0] = rd_req;
    for (int i = 1; i < RD_LAT; i++) infl_sr_d[i] = infl_sr_q[i-1];
    word_cnt_d   = word_cnt_q + {15'd0, pop};
  end

  always_ff @(posedge rd_clk) begin
    if (sync_clr) begin
      buf_q       <= '0;
      occ_q       <= 3'd0;
      infl_sr_q   <= '0;
      skew_q      <= 4'd0;
      lane_err_q  <= 1'b0;
      err_lanes_q <= 10'h000;
      clr_pend_q  <= 1'b0;
      word_cnt_q  <= 16'd0;
    end else begin
      buf_q       <= buf_d;
      occ_q       <= occ_d;
      infl_sr_q   <= infl_sr_d;
      skew_q      <= skew_d;
      lane_err_q  <= lane_err_d;
      err_lanes_q <= err_lanes_d;
      clr_pend_q  <= clr_pend_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

endmodule
